// File: rtl/student_fir_result_combiner_pkg.sv
// Shared types and helpers for the FIR result combiner: FSM encoding,
// accumulator width and saturation bounds.
package student_fir_comb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        SUM,
        SCALE,
        PUSH
    } comb_state_t;

    // Room for NUM_FIR signed addends, never narrower than one extra bit.
    function automatic int unsigned sum_width(input int unsigned w, input int unsigned n);
        return (n > 1) ? w + $clog2(n) : w + 1;
    endfunction

    function automatic longint sat_hi(input int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_lo(input int unsigned w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/student_fir_result_combiner_if.sv
// Sample stream toward the audio output: FIFO head, not-empty and consumer ready.
interface student_fir_result_combiner_if #(
    parameter int unsigned DATA_SIZE = 16
);
    logic [DATA_SIZE-1:0] sample_o;
    logic                 valid_o;
    logic                 ready_i;

    modport master (output sample_o, output valid_o, input ready_i);
    modport slave  (input sample_o, input valid_o, output ready_i);
endinterface

// File: rtl/student_fwft_fifo.sv
// First-word-fall-through FIFO: head is always visible on data_o while not empty.
module student_fwft_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [PTR_W:0]   cnt_q;
    logic             wr_en, rd_en;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
    assign rd_en   = pop_i && !empty_o;
    // A push into a full FIFO is accepted only when the head leaves the same cycle.
    assign wr_en   = push_i && (!full_o || rd_en);
    assign data_o  = mem_q[rd_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
            end
            if (rd_en) rd_q <= (rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
            if (wr_en && !rd_en)      cnt_q <= cnt_q + 1'b1;
            else if (rd_en && !wr_en) cnt_q <= cnt_q - 1'b1;
        end
    end
endmodule

// File: rtl/student_fir_result_combiner.sv
// Collects one partial result per FIR slice, sums, rescales with rounding and
// saturation, and queues the sample toward the audio output.
module student_fir_result_combiner
    import student_fir_comb_pkg::*;
#(
    parameter int unsigned NUM_FIR           = 4,
    parameter int unsigned DATA_SIZE_FIR_OUT = 32,
    parameter int unsigned DATA_SIZE         = 16,
    parameter int unsigned FIFO_DEPTH        = 4,
    parameter int unsigned TIMEOUT_CYCLES    = 2048
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NUM_FIR-1:0]                   valid_strobe_in,
    input  logic [NUM_FIR*DATA_SIZE_FIR_OUT-1:0] y_in,
    input  logic [5:0]                           shift_i,
    input  logic                                 clear_i,
    student_fir_result_combiner_if.master        out_if,
    output logic                                 busy_o,
    output logic                                 overflow_o,
    output logic                                 missing_o,
    output logic                                 fifo_drop_o
);
    localparam int unsigned SUM_W  = sum_width(DATA_SIZE_FIR_OUT, NUM_FIR);
    localparam int unsigned RND_W  = SUM_W + 1;
    localparam int unsigned LANE_W = (NUM_FIR > 1) ? $clog2(NUM_FIR) : 1;
    localparam int unsigned TMR_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic signed [RND_W-1:0] SAT_HI = RND_W'(sat_hi(DATA_SIZE));
    localparam logic signed [RND_W-1:0] SAT_LO = RND_W'(sat_lo(DATA_SIZE));

    comb_state_t state_q, state_d;

    logic [NUM_FIR-1:0]           strobe_q, edge_w, mask_q;
    logic [DATA_SIZE_FIR_OUT-1:0] cap_q [NUM_FIR];
    logic [TMR_W-1:0]             timer_q;
    logic [LANE_W-1:0]            lane_q;
    logic signed [SUM_W-1:0]      acc_q, lane_val;
    logic [DATA_SIZE-1:0]         sample_q, scaled;
    logic                         push_q, clip_w;
    logic                         mask_all_w, timeout_w, last_lane_w;
    logic                         collect_en, sum_en, scale_en, push_en, lost_w;
    logic [5:0]                   shift_c;
    logic signed [RND_W-1:0]      rnd_w, shifted_w;
    logic                         fifo_full, fifo_empty, fifo_pop;

    assign edge_w      = valid_strobe_in & ~strobe_q;
    assign mask_all_w  = ((mask_q | edge_w) == '1);
    assign timeout_w   = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
    assign last_lane_w = (lane_q == LANE_W'(NUM_FIR - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (|edge_w) state_d = mask_all_w ? SUM : COLLECT;
            COLLECT: if (mask_all_w || timeout_w) state_d = SUM;
            SUM:     if (last_lane_w) state_d = SCALE;
            SCALE:   state_d = PUSH;
            PUSH:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        collect_en = (state_q == IDLE) || (state_q == COLLECT);
        sum_en     = (state_q == SUM);
        scale_en   = (state_q == SCALE);
        push_en    = (state_q == PUSH);
        busy_o     = (state_q != IDLE);
        lost_w     = (|edge_w) && (sum_en || scale_en || push_en);
    end

    // Lanes that never arrived contribute zero.
    assign lane_val = mask_q[lane_q] ? SUM_W'(signed'(cap_q[lane_q])) : '0;

    always_comb begin
        shift_c   = (shift_i > 6'(SUM_W - 1)) ? 6'(SUM_W - 1) : shift_i;
        rnd_w     = RND_W'(acc_q) + ((shift_c != '0) ? (RND_W'(1) << (shift_c - 6'd1)) : '0);
        shifted_w = rnd_w >>> shift_c;
        clip_w    = 1'b0;
        scaled    = shifted_w[DATA_SIZE-1:0];
        if (shifted_w > SAT_HI) begin
            scaled = SAT_HI[DATA_SIZE-1:0];
            clip_w = 1'b1;
        end else if (shifted_w < SAT_LO) begin
            scaled = SAT_LO[DATA_SIZE-1:0];
            clip_w = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            strobe_q <= '0;
            mask_q   <= '0;
            timer_q  <= '0;
            lane_q   <= '0;
            acc_q    <= '0;
            sample_q <= '0;
            push_q   <= 1'b0;
            for (int unsigned i = 0; i < NUM_FIR; i++) cap_q[i] <= '0;
        end else begin
            strobe_q <= valid_strobe_in;
            push_q   <= push_en;
            timer_q  <= (state_q == COLLECT) ? timer_q + 1'b1 : '0;
            if (collect_en) begin
                for (int unsigned i = 0; i < NUM_FIR; i++)
                    if (edge_w[i] && !mask_q[i])
                        cap_q[i] <= y_in[i*DATA_SIZE_FIR_OUT +: DATA_SIZE_FIR_OUT];
                mask_q <= mask_q | edge_w;
            end else if (push_en) begin
                mask_q <= '0;
            end
            if (sum_en) begin
                acc_q  <= acc_q + lane_val;
                lane_q <= last_lane_w ? '0 : lane_q + 1'b1;
            end else if (push_en) begin
                acc_q <= '0;
            end
            if (scale_en) sample_q <= scaled;
        end
    end

    // The FIFO write lands one cycle after PUSH; drop is judged in that cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_o  <= 1'b0;
            missing_o   <= 1'b0;
            fifo_drop_o <= 1'b0;
        end else begin
            if (scale_en && clip_w) overflow_o <= 1'b1;
            else if (clear_i)       overflow_o <= 1'b0;
            if ((state_q == COLLECT && timeout_w && !mask_all_w) || lost_w) missing_o <= 1'b1;
            else if (clear_i)                                               missing_o <= 1'b0;
            if (push_q && fifo_full && !fifo_pop) fifo_drop_o <= 1'b1;
            else if (clear_i)                     fifo_drop_o <= 1'b0;
        end
    end

    assign fifo_pop       = !fifo_empty && out_if.ready_i;
    assign out_if.valid_o = !fifo_empty;

    student_fwft_fifo #(
        .WIDTH (DATA_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push_q),
        .data_i  (sample_q),
        .pop_i   (fifo_pop),
        .data_o  (out_if.sample_o),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );
endmodule

// File: tb/tb_student_fir_result_combiner.sv
// Directed bench for the FIR result combiner: arithmetic model of sum/round/saturate
// feeding an expected-sample queue, checked on every output handshake.
module tb_student_fir_result_combiner;
    localparam int unsigned NF = 4;
    localparam int unsigned W  = 32;
    localparam int unsigned DS = 16;
    localparam int unsigned TO = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NF-1:0]   strobe = '0;
    logic [NF*W-1:0] y = '0;
    logic [5:0]      shift = '0;
    logic            clear = 1'b0;
    logic            busy, ovf, miss, drop;

    always #5 clk = ~clk;

    student_fir_result_combiner_if #(.DATA_SIZE(DS)) out_if ();

    student_fir_result_combiner #(
        .NUM_FIR           (NF),
        .DATA_SIZE_FIR_OUT (W),
        .DATA_SIZE         (DS),
        .FIFO_DEPTH        (4),
        .TIMEOUT_CYCLES    (TO)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .valid_strobe_in (strobe),
        .y_in            (y),
        .shift_i         (shift),
        .clear_i         (clear),
        .out_if          (out_if),
        .busy_o          (busy),
        .overflow_o      (ovf),
        .missing_o       (miss),
        .fifo_drop_o     (drop)
    );

    int          n_checks = 0;
    int          n_pass = 0;
    logic [15:0] mq [$];
    bit          exp_ovf = 0, exp_miss = 0, exp_drop = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Sum of signed lanes, shifted with round-half-up, clipped to 16 bits.
    function automatic logic [15:0] model_sample(input longint sum, input int sh, output bit clip);
        longint s, r;
        s = (sh > 33) ? 33 : sh;
        r = sum + ((s != 0) ? (64'sd1 <<< (s - 1)) : 64'sd0);
        r = r >>> s;
        clip = 0;
        if (r > 32767) begin
            r = 32767;
            clip = 1;
        end else if (r < -32768) begin
            r = -32768;
            clip = 1;
        end
        return r[15:0];
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (out_if.valid_o && out_if.ready_i) begin
                if (mq.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_sample: got %0d expected no sample", out_if.sample_o);
                end else begin
                    chk("stream_sample", out_if.sample_o, mq.pop_front());
                end
            end
        end
    end

    task automatic send_frame(input logic [31:0] v0, v1, v2, v3, input logic [3:0] m,
                              input int gap, input logic [5:0] sh, input logic [15:0] lit);
        logic [31:0] lv [4];
        longint      sum;
        bit          clip, was_empty;
        logic [15:0] e;
        int          t;
        lv  = '{v0, v1, v2, v3};
        sum = 0;
        for (int i = 0; i < 4; i++) if (m[i]) sum += longint'(signed'(lv[i]));
        e = model_sample(sum, int'(sh), clip);
        if (clip) exp_ovf = 1;
        if (m != 4'hF) exp_miss = 1;
        was_empty = (mq.size() == 0);
        if (mq.size() >= 4) exp_drop = 1;
        else mq.push_back(e);
        @(negedge clk);
        y = {v3, v2, v1, v0};
        shift = sh;
        if (gap == 0) begin
            strobe = m;
            @(negedge clk);
            strobe = '0;
            chk("busy_active", busy, 1);
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (m[i]) begin
                    strobe[i] = 1'b1;
                    @(negedge clk);
                    strobe[i] = 1'b0;
                    repeat (gap - 1) @(negedge clk);
                end
            end
        end
        if (was_empty) begin
            t = 0;
            while (!out_if.valid_o && t < int'(TO) + 20) begin
                @(negedge clk);
                t++;
            end
            chk("valid_seen", out_if.valid_o, 1);
            chk("sample_literal", out_if.sample_o, lit);
            if (gap == 0 && m == 4'hF) chk("latency", t, 7);
            repeat (6) @(negedge clk);
        end else begin
            repeat ((m == 4'hF) ? 12 : int'(TO) + 12) @(negedge clk);
        end
        chk("busy_idle", busy, 0);
        chk("overflow_flag", ovf, exp_ovf);
        chk("missing_flag", miss, exp_miss);
        chk("drop_flag", drop, exp_drop);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        exp_ovf = 0;
        exp_miss = 0;
        exp_drop = 0;
        chk("clear_ovf", ovf, 0);
        chk("clear_miss", miss, 0);
        chk("clear_drop", drop, 0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_sample", out_if.sample_o, 0);
        chk("rst_valid", out_if.valid_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_miss", miss, 0);
        chk("rst_drop", drop, 0);
    endtask

    initial begin
        bit c;
        int t;
        out_if.ready_i = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        send_frame(32'd100, 32'd200, 32'd300, 32'd400, 4'hF, 0, 6'd0, 16'd1000);
        send_frame(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 4'hF, 3, 6'd4, 16'd16384);
        send_frame(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'hF, 0, 6'd0, 16'h7FFF);
        send_frame(32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 4'hF, 0, 6'd0, 16'h8000);
        do_clear();

        send_frame(32'd3, 32'd0, 32'd0, 32'd0, 4'hF, 0, 6'd1, 16'd2);
        send_frame(32'hFFFF_FFFD, 32'd0, 32'd0, 32'd0, 4'hF, 0, 6'd1, 16'hFFFF);
        send_frame(32'd5, 32'd0, 32'd0, 32'd0, 4'hF, 0, 6'd63, 16'd0);

        send_frame(32'd5, 32'd7, 32'd0, 32'd0, 4'b0011, 0, 6'd0, 16'd12);
        do_clear();

        // Late strobe while summing: flagged, captured values stay in effect.
        mq.push_back(model_sample(10, 0, c));
        exp_miss = 1;
        @(negedge clk);
        y = {32'd4, 32'd3, 32'd2, 32'd1};
        shift = '0;
        strobe = '1;
        @(negedge clk);
        strobe = '0;
        @(negedge clk);
        y[31:0] = 32'd999;
        strobe = 4'b0001;
        @(negedge clk);
        strobe = '0;
        repeat (12) @(negedge clk);
        chk("miss_sum_strobe", miss, exp_miss);
        do_clear();

        out_if.ready_i = 1'b0;
        for (int v = 1; v <= 5; v++) send_frame(32'(v), 32'd0, 32'd0, 32'd0, 4'hF, 0, 6'd0, 16'(v));
        chk("full_valid", out_if.valid_o, 1);
        chk("full_head", out_if.sample_o, 1);
        @(negedge clk);
        out_if.ready_i = 1'b1;
        repeat (8) @(negedge clk);
        chk("drained_valid", out_if.valid_o, 0);
        do_clear();

        @(negedge clk);
        y = {32'd40, 32'd30, 32'd20, 32'd10};
        strobe = '1;
        @(negedge clk);
        strobe = '0;
        @(negedge clk);
        rst_n = 1'b0;
        mq.delete();
        exp_ovf = 0;
        exp_miss = 0;
        exp_drop = 0;
        @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send_frame(32'd100, 32'd200, 32'd300, 32'd400, 4'hF, 0, 6'd0, 16'd1000);

        t = 0;
        while (mq.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("model_drained", mq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
